clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
// PURPOSE
//   Receive-side counterpart of the clock divider. Measures the period and high time of a slow
//   incoming square wave (a divided clock or gate/PWM signal) in clk_in cycles.
//   Used in the cascaded-converter SIC setup to check divided switching clocks and gate timing.
//   Publishes a coherent period/high-time pair with a 1-cycle valid strobe.
//   Flags a lost or stuck input with a timeout.
// PARAMETERS
//   CNT_WIDTH   16       width of the counters and of the period/high-time outputs
//   MAX_PERIOD  16'hFFFF cycle count without a rising edge before timeout fires; range 4..2^CNT_WIDTH-1
// PORTS
//   clk_in         in   1          system clock (125 MHz on PYNQ)
//   rst_n          in   1          asynchronous, active-low reset
//   sig_in         in   1          measured signal, asynchronous to clk_in
//   period_out     out  CNT_WIDTH  cycles between the last two rising edges of sig_in
//   high_time_out  out  CNT_WIDTH  cycles sig_in was high within that period
//   valid_out      out  1          1-cycle strobe when period_out/high_time_out update
//   timeout_out    out  1          sticky; no rising edge within MAX_PERIOD cycles
// BEHAVIOUR
//   Reset: all outputs 0; counters 0; state S_IDLE. Reset asserted mid-measurement aborts it.
//   Input stage: 2-FF synchronizer -> sig_s; sig_d = sig_s delayed 1 cycle.
//     rise = sig_s & ~sig_d; fall = ~sig_s & sig_d. Latency is constant, so it does not affect measured values.
//   S_IDLE: wait for rise. On rise: cnt<=1, hi_cnt<=1, go to S_MEAS. No valid_out on this arming edge.
//   S_MEAS: cnt<=cnt+1 every cycle. hi_cnt<=hi_cnt+1 while sig_s=1.
//     On fall: hi_lat<=hi_cnt.
//     On rise: period_out<=cnt, high_time_out<=hi_lat, valid_out<=1 next cycle,
//       timeout_out<=0, cnt<=1, hi_cnt<=1.
//     Rising edges N cycles apart give period_out=N. High for H cycles gives high_time_out=H.
//   Timeout: cnt==MAX_PERIOD with no rise in that cycle -> timeout_out<=1, period_out<=0,
//     high_time_out<=0, state S_IDLE. Covers both stuck-high and stuck-low inputs.
//   Simultaneous rise and cnt==MAX_PERIOD: the rise wins; valid measurement with period_out=MAX_PERIOD.
//   Counters never wrap: MAX_PERIOD <= 2^CNT_WIDTH-1 guarantees timeout happens first.
//   Outputs hold between strobes. valid_out is high for exactly 1 cycle per update.
// CONFIGURATION
//   CLK_METER_AVG_EN defined:
//     - Sum 4 consecutive periods and high times into CNT_WIDTH+2-bit accumulators.
//     - Publish sum>>2 (truncating); valid_out once per 4 rising edges.
//     - Timeout or reset clears the accumulators and the 2-bit sample count.
//   CLK_METER_AVG_EN undefined: publish per period as described above; no accumulator logic.
// STRUCTURE
//   Package clock_meter_pkg: state typedef {S_IDLE, S_MEAS}; CNT_WIDTH_DEF=16; AVG_SAMPLES=4; AVG_SHIFT=2.
//   Sub-module edge_sync: 2-FF synchronizer plus rise/fall detect
//     (ports clk_in, rst_n, d_in, level_out, rise_out, fall_out).
//   Top level: FSM, counters, output registers, optional averager.
// TESTING
//   1. sig_in from a divide-by-6250 clock divider at 50% duty -> after the 2nd rise,
//      period_out=6250, high_time_out=3125, one valid_out per period.
//   2. sig_in high 3 / low 7 cycles, repeating -> period_out=10, high_time_out=3.
//      No valid_out on the first rise after reset.
//   3. MAX_PERIOD=100; hold sig_in low for 150 cycles after lock -> timeout_out=1 once cnt reaches 100,
//      outputs 0. Next two rises -> timeout_out cleared with the first valid_out.
//   4. Pulse rst_n low mid-period -> all outputs 0 immediately (asynchronous).
//      First post-reset rise only arms; the next rise gives a correct period.
//   5. Rising edges exactly MAX_PERIOD apart -> valid_out with period_out=MAX_PERIOD, no timeout.
//   6. CLK_METER_AVG_EN; periods 10,10,12,12 -> one valid_out with period_out=11.
//      Periods 10,11,11,11 -> period_out=10 (truncation).

Source files
------------

// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clock_meter_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEAS = 1'b1
    } state_e;

    localparam int CNT_WIDTH_DEF = 16;
    localparam int AVG_SAMPLES   = 4;
    localparam int AVG_SHIFT     = 2;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus one more stage
// so rising and falling edges can be detected on the synchronized level.
module edge_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    assign sync_d = {sync_q[1:0], d_in};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    // sync_q[1] is the synchronized level, sync_q[2] its one-cycle-old copy
    assign level_out = sync_q[1];
    assign rise_out  = sync_q[1] & ~sync_q[2];
    assign fall_out  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow square wave in clk_in cycles, with a sticky
// timeout for a lost/stuck input. Define CLK_METER_AVG_EN to publish 4-period averages.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int          CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int unsigned MAX_PERIOD = 16'hFFFF
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] high_time_out,
    output logic                 valid_out,
    output logic                 timeout_out
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic sig_s, rise, fall;

    edge_sync u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .d_in     (sig_in),
        .level_out(sig_s),
        .rise_out (rise),
        .fall_out (fall)
    );

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    logic                 meas_rise, tmo, publish;
    logic [CNT_WIDTH-1:0] pub_per, pub_hi;

    assign meas_rise = (state_q == S_MEAS) && rise;
    // A rise in the same cycle as the limit is a valid MAX_PERIOD measurement
    assign tmo       = (state_q == S_MEAS) && !rise && (cnt_q == MAX_CNT);

`ifdef CLK_METER_AVG_EN
    logic [CNT_WIDTH+1:0] acc_per_q, acc_per_d;
    logic [CNT_WIDTH+1:0] acc_hi_q, acc_hi_d;
    logic [1:0]           smp_q, smp_d;
    logic [CNT_WIDTH+1:0] sum_per, sum_hi;

    assign sum_per = acc_per_q + {2'b00, cnt_q};
    assign sum_hi  = acc_hi_q + {2'b00, hi_lat_q};
    assign publish = meas_rise && (smp_q == 2'(AVG_SAMPLES - 1));
    assign pub_per = sum_per[CNT_WIDTH+AVG_SHIFT-1:AVG_SHIFT];
    assign pub_hi  = sum_hi[CNT_WIDTH+AVG_SHIFT-1:AVG_SHIFT];

    always_comb begin
        acc_per_d = acc_per_q;
        acc_hi_d  = acc_hi_q;
        smp_d     = smp_q;
        if (tmo) begin
            acc_per_d = '0;
            acc_hi_d  = '0;
            smp_d     = '0;
        end else if (meas_rise) begin
            smp_d     = smp_q + 2'd1;
            acc_per_d = publish ? '0 : sum_per;
            acc_hi_d  = publish ? '0 : sum_hi;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc_per_q <= '0;
            acc_hi_q  <= '0;
            smp_q     <= '0;
        end else begin
            acc_per_q <= acc_per_d;
            acc_hi_q  <= acc_hi_d;
            smp_q     <= smp_d;
        end
    end
`else
    assign publish = meas_rise;
    assign pub_per = cnt_q;
    assign pub_hi  = hi_lat_q;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (rise) state_d = S_MEAS;
            S_MEAS: if (tmo)  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_cnt_d  = hi_cnt_q;
        hi_lat_d  = hi_lat_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    cnt_d    = ONE;
                    hi_cnt_d = ONE;
                end
            end
            S_MEAS: begin
                cnt_d = cnt_q + ONE;
                if (sig_s) hi_cnt_d = hi_cnt_q + ONE;
                if (fall)  hi_lat_d = hi_cnt_q;
                if (rise) begin
                    cnt_d    = ONE;
                    hi_cnt_d = ONE;
                    if (publish) begin
                        period_d  = pub_per;
                        high_d    = pub_hi;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                    end
                end else if (tmo) begin
                    cnt_d     = '0;
                    hi_cnt_d  = '0;
                    period_d  = '0;
                    high_d    = '0;
                    timeout_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_cnt_q  <= '0;
            hi_lat_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            hi_lat_q  <= hi_lat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_out    = period_q;
    assign high_time_out = high_q;
    assign valid_out     = valid_q;
    assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: pulse-train stimulus with a reference model based on
// rise/fall cycle stamps; handles the CLK_METER_AVG_EN build too.
module tb_clock_period_meter;
    import clock_meter_pkg::*;

    localparam int W      = 16;
    localparam int TB_MAX = 6300;

    logic         clk_in = 1'b0;
    logic         rst_n  = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period_out, high_time_out;
    logic         valid_out, timeout_out;

    int          checks = 0, failures = 0, nvalid = 0;
    int unsigned cyc = 0;
    int          exp_p[$], exp_h[$];
    bit          armed = 1'b0;
    logic        tmo_exp = 1'b0;
    int unsigned rise_cyc = 0, fall_cyc = 0;
    int          acc_p = 0, acc_h = 0, acc_n = 0;
    logic        valid_prev = 1'b0;
    int          avg_pat[8] = '{10, 10, 12, 12, 10, 11, 11, 11};

    clock_period_meter #(.CNT_WIDTH(W), .MAX_PERIOD(TB_MAX)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .high_time_out(high_time_out),
        .valid_out    (valid_out),
        .timeout_out  (timeout_out)
    );

    always #4 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_avg();
        acc_p = 0; acc_h = 0; acc_n = 0;
    endtask

    // One completed measurement: either published directly or folded into a 4-sample mean
    task automatic record(input int p, input int h);
`ifdef CLK_METER_AVG_EN
        acc_p += p; acc_h += h; acc_n++;
        if (acc_n == AVG_SAMPLES) begin
            exp_p.push_back(acc_p / AVG_SAMPLES);
            exp_h.push_back(acc_h / AVG_SAMPLES);
            tmo_exp = 1'b0;
            clear_avg();
        end
`else
        exp_p.push_back(p);
        exp_h.push_back(h);
        tmo_exp = 1'b0;
`endif
    endtask

    // Called one step after a posedge; drives sig_in high for h cycles then low
    task automatic start_pulse(input int h);
        int unsigned per;
        if (armed) begin
            per = cyc - rise_cyc;
            if (per <= TB_MAX) record(int'(per), int'(fall_cyc - rise_cyc));
            else begin
                clear_avg();
                tmo_exp = 1'b1;
            end
        end
        armed    = 1'b1;
        rise_cyc = cyc;
        sig_in   = 1'b1;
        repeat (h) @(posedge clk_in);
        #1;
        fall_cyc = cyc;
        sig_in   = 1'b0;
    endtask

    task automatic hold_low(input int l);
        repeat (l) @(posedge clk_in);
        #1;
    endtask

    // Reset lands between clock edges, so outputs must clear without a clock
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_period", period_out, 0);
        chk("async_rst_high", high_time_out, 0);
        chk("async_rst_valid", valid_out, 0);
        chk("async_rst_timeout", timeout_out, 0);
        armed = 1'b0; tmo_exp = 1'b0;
        clear_avg();
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk_in) begin
        if (rst_n && valid_out) begin
            nvalid <= nvalid + 1;
            chk("valid_single_cycle", valid_prev, 0);
            chk("valid_expected", exp_p.size() > 0, 1);
            chk("timeout_clear_on_valid", timeout_out, 0);
            if (exp_p.size() > 0) begin
                chk("period", period_out, exp_p.pop_front());
                chk("high_time", high_time_out, exp_h.pop_front());
            end
        end
        valid_prev <= valid_out;
    end

    initial begin
        int nv0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_period", period_out, 0);
        chk("rst_high", high_time_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_timeout", timeout_out, 0);
        rst_n = 1'b1;
        hold_low(3);

        // 3 high / 7 low; the first rise only arms
        start_pulse(3); hold_low(7);
        chk("arm_no_valid", nvalid, 0);
        repeat (6) begin start_pulse(3); hold_low(7); end

        // divide-by-6250 at 50% duty
        repeat (3) begin start_pulse(3125); hold_low(3125); end

        // lost input -> timeout
        start_pulse(3); hold_low(TB_MAX + 50);
        chk("timeout_set", timeout_out, 1);
        chk("timeout_period", period_out, 0);
        chk("timeout_high", high_time_out, 0);
        start_pulse(3); hold_low(7);
        chk("timeout_held_after_arm", timeout_out, tmo_exp);
        repeat (5) begin start_pulse(3); hold_low(7); end
        chk("timeout_after_recovery", timeout_out, tmo_exp);

        // rises exactly MAX apart, then one cycle more
        start_pulse(100); hold_low(TB_MAX - 100);
        start_pulse(100); hold_low(TB_MAX - 100);
        start_pulse(3); hold_low(7);
        chk("max_period_no_timeout", timeout_out, tmo_exp);
        start_pulse(3); hold_low(TB_MAX - 2);
        start_pulse(3); hold_low(7);
        chk("max_plus_one_timeout", timeout_out, 1);
        chk("max_plus_one_period", period_out, 0);

        // reset mid-period
        repeat (4) begin start_pulse(4); hold_low(6); end
        start_pulse(4); hold_low(2);
        do_reset();
        hold_low(5);
        nv0 = nvalid;
        start_pulse(4); hold_low(6);
        chk("post_reset_arm_no_valid", nvalid, nv0);
        repeat (4) begin start_pulse(4); hold_low(6); end

        // averaging patterns, aligned to a fresh sample count by reset
        do_reset();
        hold_low(5);
        foreach (avg_pat[i]) begin start_pulse(5); hold_low(avg_pat[i] - 5); end
        start_pulse(5); hold_low(5);

        // random pulse train
        repeat (20) begin
            start_pulse(int'($urandom_range(1, 20)));
            hold_low(int'($urandom_range(1, 30)));
        end
        start_pulse(2); hold_low(12);
        chk("queue_drained", exp_p.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
